// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg
// Shared definitions for the game-control state machine and the blocks that
// display its state: state encoding and default pulse / countdown lengths.
package game_ctrl_pkg;

    // State encoding as seen on the debug/display 'state' port.
    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        PAUSED = 3'd1,
        RESUME = 3'd2,
        PLAY   = 3'd3,
        RESET  = 3'd4
    } game_state_e;

    localparam int unsigned DEF_RESET_CYCLES  = 16;
    localparam int unsigned DEF_RESUME_CYCLES = 1000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_timer.sv
// ctrl_timer
// Loadable down-counter that stops at zero.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   load, load_val   : synchronous load of the count (load has priority)
//   zero             : count is zero
//   count            : current count
module ctrl_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero  = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm
// Game-control state machine: holds play until every load-complete flag is
// set, runs a resume countdown after unpause, and issues a fixed-length
// game_reset pulse on a reset-button press while paused.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   pause_sw     : debounced pause switch (1 = pause requested)
//   reset_btn    : debounced reset button level
//   loaded       : per-source load-complete flags
//   pause        : 1 while the game must not advance
//   game_reset   : reset pulse to game logic
//   state        : current state encoding
//   countdown    : remaining resume cycles, 0 outside RESUME
module game_ctrl_fsm
    import game_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC         = 2,
    parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int unsigned RESUME_CYCLES = DEF_RESUME_CYCLES,
    localparam int unsigned CNT_W = $clog2(max_u(RESET_CYCLES, RESUME_CYCLES) + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pause_sw,
    input  logic             reset_btn,
    input  logic [N_SRC-1:0] loaded,
    output logic             pause,
    output logic             game_reset,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] countdown
);

    // With no countdown configured, unpausing goes straight to PLAY.
    localparam logic [2:0]       UNPAUSE_ST = (RESUME_CYCLES == 0) ? PLAY : RESUME;
    localparam logic [CNT_W-1:0] RESUME_VAL = CNT_W'(RESUME_CYCLES);
    localparam logic [CNT_W-1:0] RESET_VAL  = CNT_W'(RESET_CYCLES);

    logic [2:0]       state_q, state_d;
    logic             pause_q, pause_d;
    logic             game_reset_q, game_reset_d;
    logic             btn_q, btn_d;

    logic             all_loaded;
    logic             press;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;
    logic [CNT_W-1:0] timer_count;
    logic             timer_done;

    assign all_loaded = &loaded;
    // Edge is taken against the registered level, so a press acts in the
    // same cycle it is first sampled.
    assign press      = reset_btn & ~btn_q;
    assign btn_d      = reset_btn;
    // Leaving on count==1 gives exactly N cycles in the timed state; zero
    // guards against a timed state ever being entered with an empty count.
    assign timer_done = timer_zero | (timer_count == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = '0;

        case (state_q)
            LOAD: begin
                if (all_loaded) begin
                    state_d = pause_sw ? PAUSED : UNPAUSE_ST;
                end
            end
            PAUSED: begin
                if (!all_loaded) begin
                    state_d = LOAD;
                end else if (press) begin
                    state_d = RESET;
                end else if (!pause_sw) begin
                    state_d = UNPAUSE_ST;
                end
            end
            RESUME: begin
                if (!all_loaded) begin
                    state_d = LOAD;
                end else if (pause_sw) begin
                    state_d = PAUSED;
                end else if (timer_done) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (!all_loaded) begin
                    state_d = LOAD;
                end else if (pause_sw) begin
                    state_d = PAUSED;
                end
            end
            RESET: begin
                // Not interruptible: only the pulse length decides the exit.
                if (timer_done) begin
                    state_d = all_loaded ? PAUSED : LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        // The shared timer is (re)loaded on entry to either timed state.
        if (state_d == RESUME && state_q != RESUME) begin
            timer_load = 1'b1;
            timer_val  = RESUME_VAL;
        end else if (state_d == RESET && state_q != RESET) begin
            timer_load = 1'b1;
            timer_val  = RESET_VAL;
        end

        pause_d      = (state_d != PLAY);
        game_reset_d = (state_d == RESET);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LOAD;
            pause_q      <= 1'b1;
            game_reset_q <= 1'b0;
            btn_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pause_q      <= pause_d;
            game_reset_q <= game_reset_d;
            btn_q        <= btn_d;
        end
    end

    ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero),
        .count    (timer_count)
    );

    assign pause      = pause_q;
    assign game_reset = game_reset_q;
    assign state      = state_q;
    // The timer also runs during RESET; only expose it while resuming.
    assign countdown  = (state_q == RESUME) ? timer_count : '0;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb_game_ctrl_fsm
// Bench for game_ctrl_fsm: instance A uses the default lengths (16 / 1000),
// instance B uses a 3-cycle reset pulse and no resume countdown. Both share
// the same stimulus and are followed by a behavioural reference model.
module tb_game_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pause_sw = 1'b0;
    logic       reset_btn = 1'b0;
    logic [1:0] loaded = 2'b00;

    logic       pause_a, game_reset_a;
    logic [2:0] state_a;
    logic [9:0] countdown_a;
    logic       pause_b, game_reset_b;
    logic [2:0] state_b;
    logic [1:0] countdown_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_ctrl_fsm #(
        .N_SRC(2), .RESET_CYCLES(16), .RESUME_CYCLES(1000)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pause_sw(pause_sw), .reset_btn(reset_btn),
        .loaded(loaded), .pause(pause_a), .game_reset(game_reset_a),
        .state(state_a), .countdown(countdown_a)
    );

    game_ctrl_fsm #(
        .N_SRC(2), .RESET_CYCLES(3), .RESUME_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pause_sw(pause_sw), .reset_btn(reset_btn),
        .loaded(loaded), .pause(pause_b), .game_reset(game_reset_b),
        .state(state_b), .countdown(countdown_b)
    );

    // Reference model: mode number plus cycles remaining in a timed mode.
    typedef struct {
        int st;
        int cnt;
        bit prev;
    } mdl_t;

    mdl_t ma = '{0, 0, 1'b0};
    mdl_t mb = '{0, 0, 1'b0};

    function automatic mdl_t mdl_next(input mdl_t m, input bit psw, input bit btn,
                                      input bit [1:0] ld, input int rr, input int rc);
        mdl_t n;
        bit   all;
        bit   pr;
        n      = m;
        all    = (ld == 2'b11);
        pr     = btn && !m.prev;
        n.prev = btn;
        case (m.st)
            0: if (all) begin
                if (psw) n.st = 1;
                else if (rc == 0) n.st = 3;
                else begin n.st = 2; n.cnt = rc; end
            end
            1: if (!all) n.st = 0;
               else if (pr) begin n.st = 4; n.cnt = rr; end
               else if (!psw) begin
                   if (rc == 0) n.st = 3;
                   else begin n.st = 2; n.cnt = rc; end
               end
            2: if (!all) begin n.st = 0; n.cnt = 0; end
               else if (psw) begin n.st = 1; n.cnt = 0; end
               else if (m.cnt <= 1) begin n.st = 3; n.cnt = 0; end
               else n.cnt = m.cnt - 1;
            3: if (!all) n.st = 0;
               else if (psw) n.st = 1;
            4: if (m.cnt <= 1) begin n.st = all ? 1 : 0; n.cnt = 0; end
               else n.cnt = m.cnt - 1;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma <= '{0, 0, 1'b0};
            mb <= '{0, 0, 1'b0};
        end else begin
            ma <= mdl_next(ma, pause_sw, reset_btn, loaded, 16, 1000);
            mb <= mdl_next(mb, pause_sw, reset_btn, loaded, 3, 0);
        end
    end

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_a); end
        checks++; if (pause_a !== 1'b1) begin errors++; $display("FAIL reset_pause: got %0b expected 1", pause_a); end
        checks++; if (game_reset_a !== 1'b0) begin errors++; $display("FAIL reset_game_reset: got %0b expected 0", game_reset_a); end
        checks++; if (countdown_a !== 10'd0) begin errors++; $display("FAIL reset_countdown: got %0d expected 0", countdown_a); end
        reset_n = 1'b1;
    endtask

    task automatic test_boot();
        loaded   = 2'b01;
        pause_sw = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++; if (state_a !== 3'd0 || pause_a !== 1'b1) begin
                errors++; $display("FAIL boot_hold cycle %0d: got state %0d pause %0b expected state 0 pause 1", i, state_a, pause_a);
            end
        end
        loaded = 2'b11;
        tick();
        checks++; if (state_a !== 3'd1) begin errors++; $display("FAIL boot_to_paused_a: got %0d expected 1", state_a); end
        checks++; if (state_b !== 3'd1) begin errors++; $display("FAIL boot_to_paused_b: got %0d expected 1", state_b); end
    endtask

    task automatic test_resume();
        pause_sw = 1'b0;
        tick();
        checks++; if (state_b !== 3'd3 || pause_b !== 1'b0) begin
            errors++; $display("FAIL resume_zero_b: got state %0d pause %0b expected state 3 pause 0", state_b, pause_b);
        end
        for (int i = 0; i < 1000; i++) begin
            checks++; if (state_a !== 3'd2 || pause_a !== 1'b1 || countdown_a !== 10'(1000 - i)) begin
                errors++; $display("FAIL resume_count step %0d: got state %0d pause %0b cnt %0d expected state 2 pause 1 cnt %0d",
                                   i, state_a, pause_a, countdown_a, 1000 - i);
            end
            tick();
        end
        checks++; if (state_a !== 3'd3 || pause_a !== 1'b0 || countdown_a !== 10'd0) begin
            errors++; $display("FAIL resume_play_a: got state %0d pause %0b cnt %0d expected state 3 pause 0 cnt 0", state_a, pause_a, countdown_a);
        end
    endtask

    task automatic test_reset_pulse();
        int na, nb;
        pause_sw = 1'b1;
        tick();
        reset_btn = 1'b1;
        tick();
        na = 0; nb = 0;
        for (int i = 0; i < 30; i++) begin
            if (game_reset_a === 1'b1) na++;
            if (game_reset_b === 1'b1) nb++;
            tick();
        end
        checks++; if (na != 16) begin errors++; $display("FAIL pulse_len_a: got %0d expected 16", na); end
        checks++; if (nb != 3) begin errors++; $display("FAIL pulse_len_b: got %0d expected 3", nb); end
        checks++; if (state_a !== 3'd1) begin errors++; $display("FAIL pulse_return_a: got %0d expected 1", state_a); end
        // Press while playing is discarded; holding it into PAUSED is too.
        reset_btn = 1'b0;
        pause_sw  = 1'b0;
        tick();
        repeat (1000) tick();
        checks++; if (state_a !== 3'd3) begin errors++; $display("FAIL reach_play_a: got %0d expected 3", state_a); end
        reset_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (game_reset_a !== 1'b0 || game_reset_b !== 1'b0) begin
                errors++; $display("FAIL press_in_play: got a=%0b b=%0b expected 0", game_reset_a, game_reset_b);
            end
        end
        pause_sw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (game_reset_a !== 1'b0 || state_a !== 3'd1 || game_reset_b !== 1'b0) begin
                errors++; $display("FAIL held_into_paused: got state %0d reset a=%0b b=%0b expected state 1 reset 0",
                                   state_a, game_reset_a, game_reset_b);
            end
        end
        reset_btn = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        pause_sw = 1'b0;
        tick();
        repeat (600) tick();
        checks++; if (countdown_a !== 10'd400) begin errors++; $display("FAIL abort_at_400: got %0d expected 400", countdown_a); end
        pause_sw = 1'b1;
        tick();
        checks++; if (state_a !== 3'd1 || countdown_a !== 10'd0) begin
            errors++; $display("FAIL abort_paused: got state %0d cnt %0d expected state 1 cnt 0", state_a, countdown_a);
        end
        pause_sw = 1'b0;
        tick();
        repeat (1000) tick();
        checks++; if (state_a !== 3'd3) begin errors++; $display("FAIL abort_replay: got %0d expected 3", state_a); end
        loaded = 2'b01;
        tick();
        checks++; if (state_a !== 3'd0 || pause_a !== 1'b1) begin
            errors++; $display("FAIL load_loss_play: got state %0d pause %0b expected state 0 pause 1", state_a, pause_a);
        end
    endtask

    task automatic test_reset_interrupt();
        int n;
        loaded   = 2'b11;
        pause_sw = 1'b1;
        tick();
        reset_btn = 1'b0;
        tick();
        reset_btn = 1'b1;
        tick();
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (game_reset_a === 1'b1) n++;
            if (k == 5) loaded = 2'b10;
            tick();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL interrupt_pulse_len: got %0d expected 16", n); end
        checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL interrupt_to_load: got %0d expected 0", state_a); end
        reset_btn = 1'b0;
        loaded    = 2'b11;
        tick();
        checks++; if (state_a !== 3'd1) begin errors++; $display("FAIL interrupt_repause: got %0d expected 1", state_a); end
        reset_btn = 1'b1;
        tick();
        repeat (7) tick();
        checks++; if (game_reset_a !== 1'b1) begin errors++; $display("FAIL pulse_cycle8: got %0b expected 1", game_reset_a); end
        reset_n = 1'b0;
        #1;
        checks++; if (game_reset_a !== 1'b0 || state_a !== 3'd0 || pause_a !== 1'b1 || countdown_a !== 10'd0) begin
            errors++; $display("FAIL async_abort: got reset %0b state %0d pause %0b cnt %0d expected 0 0 1 0",
                               game_reset_a, state_a, pause_a, countdown_a);
        end
        @(negedge clk);
        reset_btn = 1'b0;
        reset_n   = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) loaded = 2'($urandom_range(0, 3));
            else loaded = 2'b11;
            if ($urandom_range(0, 599) == 0) pause_sw = ~pause_sw;
            if ($urandom_range(0, 9) == 0) reset_btn = ~reset_btn;
            tick();
            checks++; if (state_a !== 3'(ma.st) || pause_a !== (ma.st != 3) || game_reset_a !== (ma.st == 4)
                          || countdown_a !== 10'((ma.st == 2) ? ma.cnt : 0)) begin
                errors++; $display("FAIL random_a cycle %0d: got st %0d p %0b r %0b c %0d expected st %0d c %0d",
                                   i, state_a, pause_a, game_reset_a, countdown_a, ma.st, (ma.st == 2) ? ma.cnt : 0);
            end
            checks++; if (state_b !== 3'(mb.st) || pause_b !== (mb.st != 3) || game_reset_b !== (mb.st == 4)
                          || countdown_b !== 2'd0) begin
                errors++; $display("FAIL random_b cycle %0d: got st %0d p %0b r %0b c %0d expected st %0d",
                                   i, state_b, pause_b, game_reset_b, countdown_b, mb.st);
            end
        end
    endtask

    task automatic test_illegal();
        loaded    = 2'b11;
        pause_sw  = 1'b1;
        reset_btn = 1'b0;
        tick();
        tick();
        force dut_a.state_q = 3'd6;
        #1;
        release dut_a.state_q;
        tick();
        checks++; if (state_a !== 3'd0 || pause_a !== 1'b1) begin
            errors++; $display("FAIL illegal_recover: got state %0d pause %0b expected state 0 pause 1", state_a, pause_a);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_resume();
        test_reset_pulse();
        test_abort();
        test_reset_interrupt();
        test_random();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl_fsm.md
# game_ctrl_fsm

Top-level game-control state machine for the Nexys4 game, replacing the single-register pause/reset logic. It gates play on N independent load-complete flags (song, note data, graphics and so on). It adds a timed resume countdown after unpause and a game-reset pulse of fixed, parametrised length. It sits between the debounced switch and button inputs and every block that consumes `pause` and `game_reset`.

## Interface
Parameters:
- `N_SRC`, default 2: number of load-complete flags; must be at least 1.
- `RESET_CYCLES`, default 16: length of the `game_reset` pulse in clk cycles; must be at least 1.
- `RESUME_CYCLES`, default 1000: countdown length between unpause and play; 0 means no countdown.
- `CNT_W`, derived: clog2(max(RESET_CYCLES, RESUME_CYCLES)+1). Not user-set.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `pause_sw`, in, 1: debounced pause switch; 1 requests pause.
- `reset_btn`, in, 1: debounced reset button, level input.
- `loaded`, in, N_SRC: per-source load-complete flags, level inputs.
- `pause`, out, 1: 1 while the game must not advance.
- `game_reset`, out, 1: reset pulse to game logic.
- `state`, out, 3: current state encoding, for debug and display.
- `countdown`, out, CNT_W: remaining resume cycles; 0 outside RESUME.

## Operation
- Definition: `all_loaded` = AND of all `loaded` bits.
- Reset edge detect: `reset_btn` is registered internally. A press is a 0→1 edge.
- A press is honoured only in PAUSED. A press in any other state is discarded.
- A button held across entry to PAUSED does not trigger a reset.

States and transitions; the first matching rule wins:
- LOAD (0): `pause`=1.
  - `all_loaded` and `pause_sw`=1 → PAUSED.
  - `all_loaded` and `pause_sw`=0 → RESUME.
- PAUSED (1): `pause`=1.
  - `!all_loaded` → LOAD.
  - Press → RESET.
  - `pause_sw`=0 → RESUME.
- RESUME (2): `pause`=1.
  - `!all_loaded` → LOAD.
  - `pause_sw`=1 → PAUSED; countdown aborted and zeroed.
  - Countdown reaches 0 → PLAY.
  - With RESUME_CYCLES=0, RESUME is skipped: the transition goes straight to PLAY.
- PLAY (3): `pause`=0.
  - `!all_loaded` → LOAD.
  - `pause_sw`=1 → PAUSED.
- RESET (4): `pause`=1, `game_reset`=1.
  - Not interruptible; loss of load and switch changes are ignored.
  - After RESET_CYCLES cycles: → PAUSED if `all_loaded`, else → LOAD.
- Encodings 5–7 are illegal and recover to LOAD on the next clock.

## Timing
- Reset values: state=LOAD, `pause`=1, `game_reset`=0, `countdown`=0, edge register=0.
- All outputs are registered Moore outputs. An input sampled at edge k changes the outputs at edge k, so they are visible in cycle k+1.
- `countdown`:
  - Loads RESUME_CYCLES on entry to RESUME.
  - Decrements by 1 per cycle.
  - PLAY is entered on the edge after the cycle in which `countdown`=1.
  - `pause` is therefore high for exactly RESUME_CYCLES cycles after the entry edge.
- `game_reset` is high for exactly RESET_CYCLES consecutive cycles per accepted press.
- Press detection: the edge register adds no extra latency. A 0→1 change sampled at edge k while in PAUSED enters RESET at edge k.
- Simultaneous events in PAUSED: press and `pause_sw` falling in the same cycle → RESET wins.
- Simultaneous events anywhere: loss of load has the highest priority everywhere except RESET.
- Asynchronous reset mid-RESET or mid-RESUME terminates immediately with the reset values above. No residual pulse.

## Structure
- Package `game_ctrl_pkg` holds:
  - The state encoding localparams: LOAD=0, PAUSED=1, RESUME=2, PLAY=3, RESET=4.
  - The default RESET_CYCLES and RESUME_CYCLES constants, shared with the display block that shows the state.
- Sub-module `ctrl_timer`: a parametrised CNT_W down-counter with `load`, `load_val`, `zero` and `count`.
  - One instance is shared by RESET and RESUME; the two states are mutually exclusive.
- The edge detector and next-state logic stay inline.

## Test plan
- Boot: `reset_n` low then high; `loaded`=2'b01 for 50 cycles → state=LOAD and `pause`=1 throughout. `loaded`=2'b11 with `pause_sw`=1 → PAUSED one cycle later.
- Resume: from PAUSED, `pause_sw`→0 with RESUME_CYCLES=1000 → `countdown` runs 1000…1 and `pause`=1 for 1000 cycles, then `pause`=0 in PLAY. Rerun with RESUME_CYCLES=0 → PLAY in one cycle.
- Reset pulse: in PAUSED, press `reset_btn` → `game_reset`=1 for exactly 16 cycles, then PAUSED. A press in PLAY gives no pulse. A button held from PLAY through `pause_sw`=1 gives no pulse.
- Abort and priority: in RESUME at `countdown`=400, `pause_sw`=1 → PAUSED and `countdown`=0. In PLAY, drop `loaded[1]` → LOAD and `pause`=1 next cycle.
- Reset interruption: during RESET, drop `loaded[0]` at cycle 5 → the pulse still lasts 16 cycles, then LOAD. Assert `reset_n` low at pulse cycle 8 → `game_reset`=0 and state=LOAD immediately.
- Recovery: force illegal state 6 → LOAD next clock.
